// File: rtl/layer_pingpong_seq_if.sv
// Handshake bundle between the layer sequencer, its controller and the EPU.
interface layer_pingpong_seq_if #(
   parameter int unsigned LAYER_W = 8
) ();
   logic               start_i;
   logic [LAYER_W-1:0] layer_num_i;
   logic               abort_i;
   logic               epu_done_i;
   logic               epu_start_o;
   logic               inout_trans_o;
   logic [LAYER_W-1:0] layer_idx_o;
   logic               busy_o;
   logic               done_o;
   logic               error_o;

   modport master (
      output start_i, layer_num_i, abort_i, epu_done_i,
      input  epu_start_o, inout_trans_o, layer_idx_o, busy_o, done_o, error_o
   );

   modport slave (
      input  start_i, layer_num_i, abort_i, epu_done_i,
      output epu_start_o, inout_trans_o, layer_idx_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/layer_pingpong_seq.sv
// Layer sequencer: runs N EPU layers, toggling the in/out buffer swap between layers.
// Optional per-layer watchdog enabled by defining LAYER_TIMEOUT_EN.
module layer_pingpong_seq #(
   parameter int unsigned LAYER_W        = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst,
   layer_pingpong_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_SWAP,
      S_FINISH
   } state_e;

   state_e             state_q, state_d;
   logic [LAYER_W-1:0] total_q, total_d;
   logic [LAYER_W-1:0] idx_q, idx_d;
   logic               trans_q, trans_d;
   logic               epu_start_q, epu_start_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic accept_c;
   logic zero_req_c;
   logic last_c;
   logic timeout_c;

   assign accept_c   = (state_q == S_IDLE) && bus.start_i && !bus.abort_i && (bus.layer_num_i != '0);
   assign zero_req_c = (state_q == S_IDLE) && bus.start_i && !bus.abort_i && (bus.layer_num_i == '0);
   assign last_c     = (idx_q == total_q - LAYER_W'(1));

`ifdef LAYER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Cycles spent in RUN; zero on every entry
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == S_RUN) begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // A done arriving on the limit cycle wins over the timeout
   assign timeout_c = (state_q == S_RUN) && !bus.epu_done_i &&
                      (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_cfg_c;

   assign unused_cfg_c = (TIMEOUT_CYCLES == 0);
   assign timeout_c    = 1'b0;
`endif

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         total_q     <= '0;
         idx_q       <= '0;
         trans_q     <= 1'b0;
         epu_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         idx_q       <= idx_d;
         trans_q     <= trans_d;
         epu_start_q <= epu_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Next-state logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      if (bus.abort_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:   if (accept_c) state_d = S_START;
            S_START:  state_d = S_RUN;
            S_RUN: begin
               if (bus.epu_done_i) begin
                  state_d = last_c ? S_FINISH : S_SWAP;
               end else if (timeout_c) begin
                  state_d = S_IDLE;
               end
            end
            S_SWAP:   state_d = S_START;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Output/datapath next values, registered alongside the state
   always_comb begin
      total_d     = total_q;
      idx_d       = idx_q;
      trans_d     = trans_q;
      error_d     = error_q;
      epu_start_d = (state_d == S_START);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FINISH) || zero_req_c;
      if (bus.abort_i) begin
         idx_d   = '0;
         trans_d = 1'b0;
      end else if (accept_c) begin
         total_d = bus.layer_num_i;
         idx_d   = '0;
         trans_d = 1'b0;
         error_d = 1'b0;
      end else if ((state_q == S_RUN) && (state_d == S_SWAP)) begin
         idx_d   = idx_q + LAYER_W'(1);
         trans_d = !trans_q;
      end else if (timeout_c) begin
         error_d = 1'b1;
      end
   end

   assign bus.epu_start_o   = epu_start_q;
   assign bus.inout_trans_o = trans_q;
   assign bus.layer_idx_o   = idx_q;
   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;
   assign bus.error_o       = error_q;

endmodule

// File: tb/tb_layer_pingpong_seq.sv
// Scoreboard bench for layer_pingpong_seq; define LAYER_TIMEOUT_EN to also cover the watchdog.
module tb_layer_pingpong_seq;

   localparam int unsigned LAYER_W = 8;
   localparam int unsigned TMO     = 16;
   localparam int          EPU_DLY = 10;

   typedef struct {
      int idx;
      bit trans;
   } start_exp_t;

   typedef struct {
      bit trans;
      int cyc;
   } done_exp_t;

   logic clk = 1'b0;
   logic rst;
   logic done_auto;
   logic done_man;
   bit   epu_auto;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int accept_cyc    = 0;
   int last_done_cyc = 0;

   start_exp_t start_q[$];
   done_exp_t  done_q[$];
   start_exp_t mon_se;
   done_exp_t  mon_de;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   layer_pingpong_seq_if #(.LAYER_W(LAYER_W)) bus ();

   layer_pingpong_seq #(
      .LAYER_W       (LAYER_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.epu_done_i = done_auto | done_man;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input int num);
      bus.layer_num_i = LAYER_W'(num);
      bus.start_i     = 1'b1;
      accept_cyc      = cyc;
      tick();
      bus.start_i     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_q.size() == 0 && start_q.size() == 0) break;
         tick();
      end
      check("wait_done_budget", done_q.size(), 0);
   endtask

   // EPU model: answers each epu_start_o with a done pulse EPU_DLY cycles later
   always begin
      @(negedge clk);
      if (bus.epu_start_o && epu_auto && !rst) begin
         repeat (EPU_DLY) @(posedge clk);
         #1;
         done_auto     = 1'b1;
         last_done_cyc = cyc;
         @(posedge clk);
         #1;
         done_auto     = 1'b0;
      end
   end

   // Monitor: pops expected start/done events as the DUT produces them
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.epu_start_o) begin
            if (start_q.size() == 0) begin
               check("unexp_epu_start", 32'(bus.epu_start_o), 0);
            end else begin
               mon_se = start_q.pop_front();
               check("start_idx", 32'(bus.layer_idx_o), mon_se.idx);
               check("start_trans", 32'(bus.inout_trans_o), 32'(mon_se.trans));
               check("start_busy", 32'(bus.busy_o), 1);
               check("start_cyc", cyc, (mon_se.idx == 0) ? accept_cyc + 1 : last_done_cyc + 2);
            end
         end
         if (bus.done_o) begin
            if (done_q.size() == 0) begin
               check("unexp_done", 32'(bus.done_o), 0);
            end else begin
               mon_de = done_q.pop_front();
               check("done_trans", 32'(bus.inout_trans_o), 32'(mon_de.trans));
               check("done_cyc", cyc, (mon_de.cyc >= 0) ? mon_de.cyc : last_done_cyc + 1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst             = 1'b1;
      bus.start_i     = 1'b0;
      bus.layer_num_i = '0;
      bus.abort_i     = 1'b0;
      done_auto       = 1'b0;
      done_man        = 1'b0;
      epu_auto        = 1'b1;
      tick(3);
      rst = 1'b0;

      // Reset state
      check("rst_epu_start", 32'(bus.epu_start_o), 0);
      check("rst_trans", 32'(bus.inout_trans_o), 0);
      check("rst_idx", 32'(bus.layer_idx_o), 0);
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_done", 32'(bus.done_o), 0);
      check("rst_error", 32'(bus.error_o), 0);

      // Three layers: swap select 0,1,0
      start_q.push_back('{0, 1'b0});
      start_q.push_back('{1, 1'b1});
      start_q.push_back('{2, 1'b0});
      done_q.push_back('{1'b0, -1});
      launch(3);
      wait_done(200);
      check("seq3_busy_after", 32'(bus.busy_o), 0);
      check("seq3_idx_held", 32'(bus.layer_idx_o), 2);

      // Zero layers: immediate done, never busy
      done_q.push_back('{1'b0, cyc + 1});
      launch(0);
      for (int i = 0; i < 3; i++) begin
         check("zero_busy", 32'(bus.busy_o), 0);
         tick();
      end
      check("zero_done_seen", done_q.size(), 0);

      // Abort during the second RUN
      start_q.push_back('{0, 1'b0});
      start_q.push_back('{1, 1'b1});
      launch(4);
      for (int i = 0; i < 60; i++) begin
         if (start_q.size() == 0) break;
         tick();
      end
      check("abort_reach_run2", start_q.size(), 0);
      tick(3);
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      check("abort_busy", 32'(bus.busy_o), 0);
      check("abort_trans", 32'(bus.inout_trans_o), 0);
      check("abort_idx", 32'(bus.layer_idx_o), 0);
      tick(14);
      start_q.push_back('{0, 1'b0});
      done_q.push_back('{1'b0, -1});
      launch(1);
      wait_done(100);
      check("post_abort_trans", 32'(bus.inout_trans_o), 0);

      // Spurious epu_done in IDLE and START, start during RUN
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      check("idle_done_busy", 32'(bus.busy_o), 0);
      start_q.push_back('{0, 1'b0});
      start_q.push_back('{1, 1'b1});
      done_q.push_back('{1'b1, -1});
      launch(2);
      check("start_pulse", 32'(bus.epu_start_o), 1);
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      check("start_done_ign_idx", 32'(bus.layer_idx_o), 0);
      check("start_done_ign_busy", 32'(bus.busy_o), 1);
      tick(2);
      bus.layer_num_i = LAYER_W'(5);
      bus.start_i     = 1'b1;
      tick();
      bus.start_i     = 1'b0;
      check("run_start_ign_idx", 32'(bus.layer_idx_o), 0);
      check("run_start_ign_epu", 32'(bus.epu_start_o), 0);
      wait_done(100);
      check("seq2_trans", 32'(bus.inout_trans_o), 1);
      check("seq2_idx", 32'(bus.layer_idx_o), 1);

      // Asynchronous reset in SWAP
      start_q.push_back('{0, 1'b0});
      launch(2);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.inout_trans_o === 1'b1) break;
      end
      check("swap_seen", 32'(bus.inout_trans_o), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy_o), 0);
      check("arst_trans", 32'(bus.inout_trans_o), 0);
      check("arst_idx", 32'(bus.layer_idx_o), 0);
      check("arst_epu_start", 32'(bus.epu_start_o), 0);
      check("arst_done", 32'(bus.done_o), 0);
      tick(2);
      rst = 1'b0;
      tick(2);

`ifdef LAYER_TIMEOUT_EN
      // Watchdog: no epu_done after start
      epu_auto = 1'b0;
      start_q.push_back('{0, 1'b0});
      launch(1);
      for (int i = 0; i < 40; i++) begin
         if (bus.error_o === 1'b1) break;
         tick();
      end
      check("tmo_error", 32'(bus.error_o), 1);
      check("tmo_cyc", cyc, accept_cyc + 18);
      check("tmo_busy", 32'(bus.busy_o), 0);
      tick(3);
      check("tmo_sticky", 32'(bus.error_o), 1);
      epu_auto = 1'b1;
      start_q.push_back('{0, 1'b0});
      done_q.push_back('{1'b0, -1});
      launch(1);
      check("tmo_err_clear", 32'(bus.error_o), 0);
      wait_done(100);
`else
      check("err_tied_low", 32'(bus.error_o), 0);
`endif

      tick(5);
      check("start_q_left", start_q.size(), 0);
      check("done_q_left", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
